// File: rtl/modadd_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : modadd_ctrl
// Purpose  : Modular add/subtract controller driving a multi-cycle adder.
//            Pass 1 computes a+b or a-b; pass 2 conditionally corrects the
//            raw result by the modulus so the final value lies in 0..m-1.
// Revision : 1.0 - initial release
// ============================================================================
module modadd_ctrl #(
    parameter int N       = 512,
    parameter int TIMEOUT = 4096
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         op_sub,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [N-1:0] in_m,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [N-1:0] result,
    output logic         adder_start,
    output logic         adder_subtract,
    output logic         adder_shift,
    output logic [N+1:0] adder_in_a,
    output logic [N+1:0] adder_in_b,
    input  logic [N+2:0] adder_result,
    input  logic         adder_done
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ1  = 3'd1,
        S_WAIT1 = 3'd2,
        S_REQ2  = 3'd3,
        S_WAIT2 = 3'd4,
        S_FIN   = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_sub;
    logic [N-1:0]   r_m;
    logic [N-1:0]   r_result;
    logic           r_error;
    logic [N+1:0]   r_in_a;
    logic [N+1:0]   r_in_b;
    logic           r_asub;
    logic [CW-1:0]  r_cnt;

    logic           w_accept;
    logic           w_pass2;
    logic           w_fin;
    logic           w_to;
    logic [N-1:0]   w_fin_val;
    logic           w_neg;
    logic           w_expired;

    assign w_neg     = adder_result[N+2];
    assign w_expired = (r_cnt == CW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and the load strobes for the datapath registers
    always_comb begin
        w_next    = r_state;
        w_accept  = 1'b0;
        w_pass2   = 1'b0;
        w_fin     = 1'b0;
        w_to      = 1'b0;
        w_fin_val = '0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_REQ1;
                end
            end
            S_REQ1:  w_next = S_WAIT1;
            S_WAIT1: begin
                if (adder_done) begin
                    if (r_sub && !w_neg) begin
                        // Non-negative difference is already reduced
                        w_fin     = 1'b1;
                        w_fin_val = adder_result[N-1:0];
                        w_next    = S_FIN;
                    end else begin
                        w_pass2 = 1'b1;
                        w_next  = S_REQ2;
                    end
                end else if (w_expired) begin
                    w_fin  = 1'b1;
                    w_to   = 1'b1;
                    w_next = S_FIN;
                end
            end
            S_REQ2:  w_next = S_WAIT2;
            S_WAIT2: begin
                if (adder_done) begin
                    w_fin  = 1'b1;
                    w_next = S_FIN;
                    // For add, a negative r-m means r was already below m;
                    // r is still held on the adder's A operand.
                    if (!r_sub && w_neg) begin
                        w_fin_val = r_in_a[N-1:0];
                    end else begin
                        w_fin_val = adder_result[N-1:0];
                    end
                end else if (w_expired) begin
                    w_fin  = 1'b1;
                    w_to   = 1'b1;
                    w_next = S_FIN;
                end
            end
            S_FIN:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Operand, result and error registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sub    <= 1'b0;
            r_m      <= '0;
            r_result <= '0;
            r_error  <= 1'b0;
            r_in_a   <= '0;
            r_in_b   <= '0;
            r_asub   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_in_a  <= {2'b00, in_a};
                r_in_b  <= {2'b00, in_b};
                r_m     <= in_m;
                r_sub   <= op_sub;
                r_asub  <= op_sub;
                r_error <= 1'b0;
            end
            if (w_pass2) begin
                // Correction pass: add computes r-m, sub computes r+m
                r_in_a <= adder_result[N+1:0];
                r_in_b <= {2'b00, r_m};
                r_asub <= ~r_sub;
            end
            if (w_fin) begin
                r_result <= w_fin_val;
                r_error  <= w_to;
            end
        end
    end

    // Watchdog counter: cleared on each request, counts while waiting
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_state == S_REQ1 || r_state == S_REQ2) begin
            r_cnt <= '0;
        end else if (r_state == S_WAIT1 || r_state == S_WAIT2) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign busy           = (r_state == S_REQ1) || (r_state == S_WAIT1) ||
                            (r_state == S_REQ2) || (r_state == S_WAIT2);
    assign done           = (r_state == S_FIN);
    assign adder_start    = (r_state == S_REQ1) || (r_state == S_REQ2);
    assign error          = r_error;
    assign result         = r_result;
    assign adder_subtract = r_asub;
    assign adder_shift    = 1'b0;
    assign adder_in_a     = r_in_a;
    assign adder_in_b     = r_in_b;

endmodule
`default_nettype wire

// File: tb/tb_modadd_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_modadd_ctrl
// Purpose  : Self-checking bench for modadd_ctrl with a behavioural adder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_modadd_ctrl;

    localparam int N  = 512;
    localparam int TO = 16;

    logic         clk;
    logic         reset;
    logic         start;
    logic         op_sub;
    logic [N-1:0] in_a, in_b, in_m;
    logic         busy, done, error;
    logic [N-1:0] result;
    logic         adder_start, adder_subtract, adder_shift;
    logic [N+1:0] adder_in_a, adder_in_b;
    logic [N+2:0] adder_result;
    logic         adder_done;

    modadd_ctrl #(.N(N), .TIMEOUT(TO)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .op_sub         (op_sub),
        .in_a           (in_a),
        .in_b           (in_b),
        .in_m           (in_m),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .result         (result),
        .adder_start    (adder_start),
        .adder_subtract (adder_subtract),
        .adder_shift    (adder_shift),
        .adder_in_a     (adder_in_a),
        .adder_in_b     (adder_in_b),
        .adder_result   (adder_result),
        .adder_done     (adder_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [N-1:0] sb[$];

    task automatic chk(input string nm, input logic [N+2:0] act, input logic [N+2:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Behavioural adder: latency counted from the request cycle to done
    logic         model_done = 1'b0;
    logic [N+2:0] model_res  = '0;
    logic         stray_done = 1'b0;
    logic [N+2:0] stray_res  = '0;
    logic [N+1:0] m_a, m_b;
    logic         m_s;
    int           m_cnt = 0;
    int           l1 = 1, l2 = 1;
    bit           first_pass = 1'b1;
    bit           mute = 1'b0;
    int           n_starts = 0;
    int           n_dones = 0;

    assign adder_done   = model_done | stray_done;
    assign adder_result = stray_done ? stray_res : model_res;

    always @(negedge clk) begin
        model_done = 1'b0;
        if (adder_start) n_starts++;
        if (done) n_dones++;
        if (reset) begin
            m_cnt = 0;
        end else begin
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    chk("operand_hold",
                        {2'b0, (adder_in_a === m_a) && (adder_in_b === m_b) && (adder_subtract === m_s)},
                        1);
                    model_res  = m_s ? ({1'b0, m_a} - {1'b0, m_b}) : ({1'b0, m_a} + {1'b0, m_b});
                    model_done = 1'b1;
                end
            end
            if (adder_start) begin
                chk("start_while_pending", m_cnt, 0);
                if (!mute) begin
                    m_a   = adder_in_a;
                    m_b   = adder_in_b;
                    m_s   = adder_subtract;
                    m_cnt = first_pass ? l1 : l2;
                    first_pass = 1'b0;
                end
            end
        end
    end

    function automatic logic [N-1:0] ref_mod(input logic op, input logic [N-1:0] a, b, m);
        logic [N+1:0] t;
        if (!op) begin
            t = {2'b0, a} + {2'b0, b};
            if (t >= {2'b0, m}) t = t - {2'b0, m};
        end else if (a >= b) begin
            t = {2'b0, a} - {2'b0, b};
        end else begin
            t = {2'b0, a} + {2'b0, m} - {2'b0, b};
        end
        return t[N-1:0];
    endfunction

    function automatic logic [N-1:0] rnd_big();
        logic [N-1:0] v;
        for (int i = 0; i < N / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic wait_done(input int limit, output int cyc);
        cyc = 1;
        while (!done && cyc < limit) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_op(input logic op, input logic [N-1:0] a, b, m, ex,
                          input int ex_starts, input int lat1, input int lat2);
        int cyc;
        int s0;
        int exp_lat;
        sb.push_back(ex);
        @(negedge clk);
        l1 = lat1; l2 = lat2; first_pass = 1'b1;
        s0 = n_starts;
        start = 1'b1; op_sub = op; in_a = a; in_b = b; in_m = m;
        @(negedge clk);
        start = 1'b0;
        in_a = rnd_big(); in_b = rnd_big(); in_m = rnd_big();
        chk("busy_after_start", busy, 1);
        wait_done(200, cyc);
        if (!done) begin
            chk("done_arrives", done, 1);
            sb.delete();
            return;
        end
        exp_lat = (ex_starts == 2) ? (3 + lat1 + lat2) : (2 + lat1);
        chk("result", result, sb.pop_front());
        chk("busy_low_at_done", busy, 0);
        chk("error_clear", error, 0);
        chk("latency", cyc, exp_lat);
        @(negedge clk);
        chk("adder_start_pulses", n_starts - s0, ex_starts);
        chk("done_one_cycle", done, 0);
    endtask

    typedef struct {
        logic         op;
        logic [N-1:0] a, b, m, ex;
        int           starts;
        int           la, lb;
    } vec_t;

    vec_t tv[13];

    initial begin
        logic [N-1:0] ones;
        int cyc, s0, d0;
        #2000000;
        $display("FAIL watchdog: got no_finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [N-1:0] ones;
        int cyc, s0, d0;
        ones = '1;
        reset = 1'b1; start = 1'b0; op_sub = 1'b0;
        in_a = '0; in_b = '0; in_m = '0;

        tv[0]  = '{1'b0, 7, 9, 13, 3, 2, 3, 2};
        tv[1]  = '{1'b0, 3, 4, 13, 7, 2, 1, 1};
        tv[2]  = '{1'b1, 3, 4, 13, 12, 2, 2, 4};
        tv[3]  = '{1'b1, 9, 4, 13, 5, 1, 5, 1};
        tv[4]  = '{1'b0, ones - 1, ones - 1, ones, ones - 2, 2, 2, 3};
        tv[5]  = '{1'b1, 0, ones - 1, ones, 1, 2, 1, 2};
        tv[6]  = '{1'b0, 6, 7, 13, 0, 2, 1, 1};
        tv[7]  = '{1'b0, 0, 0, 1, 0, 2, 2, 2};
        tv[8]  = '{1'b1, 11, 11, 13, 0, 1, 3, 1};
        for (int i = 9; i < 13; i++) begin
            tv[i].op = i[0];
            tv[i].m  = rnd_big();
            tv[i].m[N-1] = 1'b1;
            tv[i].a  = rnd_big();
            tv[i].a[N-1] = 1'b0;
            tv[i].b  = rnd_big();
            tv[i].b[N-1] = 1'b0;
            tv[i].ex = ref_mod(tv[i].op, tv[i].a, tv[i].b, tv[i].m);
            tv[i].starts = (tv[i].op && tv[i].a >= tv[i].b) ? 1 : 2;
            tv[i].la = int'($urandom_range(1, 6));
            tv[i].lb = int'($urandom_range(1, 6));
        end

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_result", result, 0);
        chk("rst_adder_start", adder_start, 0);
        chk("rst_adder_sub", adder_subtract, 0);
        chk("rst_adder_shift", adder_shift, 0);
        chk("rst_adder_in_a", adder_in_a, 0);
        chk("rst_adder_in_b", adder_in_b, 0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++)
            run_op(tv[i].op, tv[i].a, tv[i].b, tv[i].m, tv[i].ex, tv[i].starts, tv[i].la, tv[i].lb);

        // Start pulsed while busy must be ignored
        s0 = n_starts; d0 = n_dones;
        sb.push_back(3);
        @(negedge clk);
        l1 = 4; l2 = 4; first_pass = 1'b1;
        start = 1'b1; op_sub = 1'b0; in_a = 7; in_b = 9; in_m = 13;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        start = 1'b1; op_sub = 1'b1; in_a = 1; in_b = 2; in_m = 5;
        @(negedge clk); start = 1'b0;
        wait_done(200, cyc);
        chk("busy_start_result", result, sb.pop_front());
        repeat (10) @(negedge clk);
        chk("busy_start_dones", n_dones - d0, 1);
        chk("busy_start_pulses", n_starts - s0, 2);

        // Reset in WAIT1 followed by a stray adder_done
        @(negedge clk);
        l1 = 10; first_pass = 1'b1;
        start = 1'b1; op_sub = 1'b0; in_a = 7; in_b = 9; in_m = 13;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
        @(negedge clk); reset = 1'b0;
        s0 = n_starts; d0 = n_dones;
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_adder_in_a", adder_in_a, 0);
        chk("abort_adder_sub", adder_subtract, 0);
        @(negedge clk);
        stray_res = 16; stray_done = 1'b1;
        @(negedge clk); stray_done = 1'b0;
        repeat (6) @(negedge clk);
        chk("abort_no_done", n_dones - d0, 0);
        chk("abort_no_start", n_starts - s0, 0);
        chk("abort_idle", busy, 0);
        chk("abort_result_hold", result, 0);

        // Adder that never answers: timeout path
        mute = 1'b1;
        s0 = n_starts;
        sb.push_back(0);
        @(negedge clk);
        start = 1'b1; op_sub = 1'b0; in_a = 7; in_b = 9; in_m = 13;
        @(negedge clk); start = 1'b0;
        wait_done(100, cyc);
        chk("timeout_done", done, 1);
        chk("timeout_latency", cyc, 2 + TO);
        chk("timeout_error", error, 1);
        chk("timeout_result", result, sb.pop_front());
        @(negedge clk);
        chk("timeout_error_sticky", error, 1);
        chk("timeout_pulses", n_starts - s0, 1);
        mute = 1'b0;
        run_op(1'b0, 7, 9, 13, 3, 2, 2, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/modadd_ctrl.md
# modadd_ctrl

Controller that issues requests to the multi-cycle `adder` over its start/done handshake to compute modular addition and subtraction for the RSA datapath. It accepts one host request with operands already reduced modulo `m`. It runs one or two adder passes: the raw operation, then a conditional correction by the modulus. It returns the result in the range 0..m-1. It sits between the Montgomery/exponentiation control and the adder instance.

## Interface
- `N`, default 512: operand/modulus width. Adder operand ports are N+2 bits; adder result port is N+3 bits.
- `TIMEOUT`, default 4096: cycles to wait for `adder_done` before flagging an error.

Ports:
- `clk`  in  1  the single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  one-cycle request strobe; accepted only in IDLE.
- `op_sub`  in  1  0: (a+b) mod m; 1: (a-b) mod m.
- `in_a`, `in_b`, `in_m`  in  N  operands and modulus; the host guarantees a,b < m and m > 0.
- `busy`  out  1  high from the cycle after an accepted start until the cycle `done` is asserted.
- `done`  out  1  one-cycle completion pulse.
- `error`  out  1  timeout flag; sticky until the next accepted start or reset.
- `result`  out  N  final value; held from `done` until the next accepted start.
- `adder_start`  out  1  one-cycle request pulse to the adder.
- `adder_subtract`  out  1  adder operation select.
- `adder_shift`  out  1  tied to 0.
- `adder_in_a`, `adder_in_b`  out  N+2  adder operands; zero-extended.
- `adder_result`  in  N+3  adder output; two's complement, bit N+2 is the sign.
- `adder_done`  in  1  adder completion pulse; `adder_result` is valid in that cycle.

## Operation
- State machine: IDLE, REQ1, WAIT1, REQ2, WAIT2, FIN.
- IDLE + `start`: register a, b, m and op_sub, clear `error`, go to REQ1.
- Pass 1, issued in REQ1 (one cycle with `adder_start`=1, then WAIT1):
  - op_sub=0: a+b.
  - op_sub=1: a-b.
- WAIT1 + `adder_done`: capture r = `adder_result`[N+1:0] and its sign s.
- Pass-2 decision:
  - Add: always go to REQ2 and compute r-m. In WAIT2, if the pass-2 result is negative, keep r; otherwise take the pass-2 result.
  - Sub: if s=0, final = r, go directly to FIN with no second pass. If s=1, go to REQ2 and compute r+m with r as N+2-bit two's complement; final = pass-2 result[N-1:0].
- FIN: drive `result` and `done`=1 for one cycle, then return to IDLE.
- `adder_in_a`, `adder_in_b` and `adder_subtract` are held stable from the REQx cycle until the matching `adder_done`. `adder_start` never rises while a pass is outstanding.
- Timeout: a counter clears on each REQx and increments in WAITx. On reaching TIMEOUT:
  - set `error`=1 and `result`=0;
  - pulse `done` through FIN;
  - return to IDLE.
- `start` while not in IDLE is ignored, with no queueing.
- `adder_done` in IDLE, REQx or FIN is ignored.
- Reset (at any time, including mid-pass) forces IDLE. Reset values:
  - `busy`, `done`, `error`, `adder_start`, `adder_subtract`, `adder_shift` = 0;
  - `result`, `adder_in_a`, `adder_in_b` = 0;
  - timeout counter = 0.
- After reset, a late `adder_done` from the aborted pass is ignored.

## Timing
- Cycle 0: `start` sampled.
- Cycle 1: REQ1, `adder_start`=1, `busy`=1.
- Pass-1 `adder_done` arrives at cycle k.
  - If a second pass is needed: `adder_start` at k+1, pass-2 `adder_done` at cycle j, `done` at j+1.
  - No second pass (sub, s=0): `done` at k+1.
- Total latency is 2 + L1 (+ 1 + L2), where L1/L2 are the adder latencies, measured from REQx to `adder_done`.
- `busy` falls in the same cycle `done` is high.
- A new `start` is accepted the cycle after `done`.
- `result` is registered and changes only in the FIN cycle or on reset.

## Test plan
- m=13, a=7, b=9, add: pass1=16, pass2=3 (non-negative) -> `result`=3, two `adder_start` pulses, one `done`.
- m=13, a=3, b=4, add: pass2=7-13 is negative -> `result`=7.
- m=13, a=3, b=4, sub: pass1=-1, pass2=-1+13 -> `result`=12. m=13, a=9, b=4, sub -> `result`=5 with exactly one `adder_start` pulse.
- N=512, m=2^512-1, a=b=2^512-2, add: pass1 = 2^513-4 (uses the carry bit) -> `result`=2^512-3. Sub with a=0, b=2^512-2 -> `result`=1.
- `reset` asserted in WAIT1, and a stray `adder_done` 3 cycles later: all outputs return to 0, no `done`, FSM stays IDLE. A `start` pulsed while busy during a normal op produces no second operation.
- Adder model that never returns `adder_done`, TIMEOUT=16: `error`=1 and `done` pulse after 16 WAIT cycles, `result`=0. The next valid request clears `error` and completes correctly.
